// File: rtl/piso_serializer.sv
// piso_serializer: valid/ready parallel-in, MSB-first serial-out with complementary output.
// Optional build macro PISO_PARITY_EN appends an even-parity bit after din[0].
module piso_serializer #(
    parameter int WIDTH = 8
) (
    input  logic             c,
    input  logic             rst,
    input  logic             load_valid,
    output logic             load_ready,
    input  logic [WIDTH-1:0] din,
    output logic             sout,
    output logic             sout_b,
    output logic             busy,
    output logic             done
);

    localparam int CW = $clog2(WIDTH + 1);

    typedef enum logic {
        IDLE  = 1'b0,
        SHIFT = 1'b1
    } state_t;

    state_t           state;
    logic [WIDTH-1:0] shreg;
    logic [CW-1:0]    cnt;
    logic             done_r;
    logic             fill_bit;

`ifdef PISO_PARITY_EN
    // The parity bit is shifted in behind the data, so it reaches the MSB one cycle after din[0].
    localparam logic [CW-1:0] LOAD_CNT = CW'(WIDTH);
    logic par_r;

    always_ff @(posedge c) begin
        if (rst) begin
            par_r <= 1'b0;
        end else if (state == IDLE && load_valid) begin
            par_r <= ^din;
        end
    end

    assign fill_bit = par_r;
`else
    localparam logic [CW-1:0] LOAD_CNT = CW'(WIDTH - 1);
    assign fill_bit = 1'b0;
`endif

    always_ff @(posedge c) begin
        if (rst) begin
            state  <= IDLE;
            shreg  <= '0;
            cnt    <= '0;
            done_r <= 1'b0;
        end else begin
            done_r <= 1'b0;
            case (state)
                IDLE: begin
                    if (load_valid) begin
                        shreg <= din;
                        cnt   <= LOAD_CNT;
                        state <= SHIFT;
                    end
                end
                SHIFT: begin
                    if (cnt != '0) begin
                        shreg <= {shreg[WIDTH-2:0], fill_bit};
                        cnt   <= cnt - 1'b1;
                    end else begin
                        state  <= IDLE;
                        shreg  <= '0;
                        done_r <= 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign sout       = shreg[WIDTH-1];
    assign sout_b     = ~shreg[WIDTH-1];
    assign busy       = (state == SHIFT);
    assign load_ready = (state == IDLE);
    assign done       = done_r;

endmodule
